// File: rtl/clk_div_seq_pkg.sv
// Shared types for the clock-divider sequencer: FSM encoding, default widths, table entry.
// Pure declarations; no logic, no latency, no flow control.
// Macro CLK_DIV_SEQ_STATUS_EN (used by the top) does not change anything here.
package clk_div_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    localparam int FACT_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    typedef struct packed {
        logic [FACT_W_DEF-1:0] fact;
        logic [CNT_W_DEF-1:0]  cycles;
    } tbl_entry_t;

endpackage

// File: rtl/clk_div_edge_counter.sv
// Rising-edge detector on the divided clock plus a saturating edge counter with terminal compare.
// Latency: term is combinational from the current sample; the count updates on the same Clk_Ref edge.
// No backpressure; clr has priority over counting, counting happens only while en is high.
module clk_div_edge_counter
    import clk_div_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk_Ref,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    input  logic             div_clk,
    input  logic [CNT_W-1:0] cycles,
`ifdef CLK_DIV_SEQ_STATUS_EN
    output logic [CNT_W-1:0] cnt,
`endif
    output logic             term
);

    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             rise;

    assign rise    = en & div_clk & ~prev_q;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign term    = rise && (cnt_inc == cycles);

`ifdef CLK_DIV_SEQ_STATUS_EN
    assign cnt = cnt_q;
`endif

    always_ff @(posedge Clk_Ref or posedge RST) begin
        if (RST) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else if (clr) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else if (en) begin
            prev_q <= div_clk;
            if (rise) begin
                cnt_q <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/clk_div_sequencer.sv
// Steps a clock divider through a programmed table of {factor, edge count}; optional Edge_Cnt under CLK_DIV_SEQ_STATUS_EN.
// Latency: Start -> LOAD +1, RUN +2; terminal divided edge -> next LOAD or Done +1.
// No backpressure: Stop wins over Start, Start and table writes are ignored while Busy.
module clk_div_sequencer
    import clk_div_seq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FACT_W = FACT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     Clk_Ref,
    input  logic                     RST,
    input  logic                     Start,
    input  logic                     Stop,
    input  logic                     Loop,
    input  logic [$clog2(DEPTH)-1:0] Last_Idx,
    input  logic                     Wr_En,
    input  logic [$clog2(DEPTH)-1:0] Wr_Addr,
    input  logic [FACT_W-1:0]        Wr_Fact,
    input  logic [CNT_W-1:0]         Wr_Cycles,
    input  logic                     Div_Clk_In,
    output logic [FACT_W-1:0]        Div_Fact,
    output logic                     Div_RST,
    output logic [$clog2(DEPTH)-1:0] Step_Idx,
    output logic                     Busy,
`ifdef CLK_DIV_SEQ_STATUS_EN
    output logic [CNT_W-1:0]         Edge_Cnt,
`endif
    output logic                     Done
);

    localparam int IDX_W = $clog2(DEPTH);

    seq_state_t        state, state_nxt;
    logic [FACT_W-1:0] tbl_fact [DEPTH];
    logic [CNT_W-1:0]  tbl_cyc  [DEPTH];
    logic [IDX_W-1:0]  idx_nxt;
    logic [FACT_W-1:0] fact_rd, fact_nxt;
    logic [CNT_W-1:0]  cyc_raw, cyc_rd;
    logic              done_nxt, term, cnt_clr, in_run;

    always_ff @(posedge Clk_Ref or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_fact[i] <= FACT_W'(1);
                tbl_cyc[i]  <= CNT_W'(1);
            end
        end else if (Wr_En && state == IDLE) begin
            tbl_fact[Wr_Addr] <= Wr_Fact;
            tbl_cyc[Wr_Addr]  <= Wr_Cycles;
        end
    end

    // Zero-valued entries are stored as written and substituted on read.
    assign cyc_raw = tbl_cyc[Step_Idx];
    assign cyc_rd  = (cyc_raw == '0) ? CNT_W'(1) : cyc_raw;
    assign in_run  = (state == RUN);
    // Clearing on the next state keeps the count at zero in every cycle outside RUN.
    assign cnt_clr = (state_nxt != RUN);

    clk_div_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .Clk_Ref (Clk_Ref),
        .RST     (RST),
        .clr     (cnt_clr),
        .en      (in_run),
        .div_clk (Div_Clk_In),
        .cycles  (cyc_rd),
`ifdef CLK_DIV_SEQ_STATUS_EN
        .cnt     (Edge_Cnt),
`endif
        .term    (term)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = Step_Idx;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                if (term) begin
                    if (Step_Idx != Last_Idx) begin
                        state_nxt = LOAD;
                        idx_nxt   = IDX_W'(Step_Idx + 1'b1);
                    end else if (Loop) begin
                        state_nxt = LOAD;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (Stop) begin
            state_nxt = IDLE;
            idx_nxt   = Step_Idx;
            done_nxt  = 1'b0;
        end
        // Factor is fetched on entry to LOAD so the registered output shows it during LOAD.
        fact_rd  = tbl_fact[idx_nxt];
        fact_nxt = Div_Fact;
        if (state_nxt == LOAD) begin
            fact_nxt = (fact_rd == '0) ? FACT_W'(1) : fact_rd;
        end
    end

    always_ff @(posedge Clk_Ref or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            Step_Idx <= '0;
            Div_Fact <= FACT_W'(1);
            Div_RST  <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            Step_Idx <= idx_nxt;
            Div_Fact <= fact_nxt;
            Div_RST  <= (state_nxt != RUN);
            Busy     <= (state_nxt != IDLE);
            Done     <= done_nxt;
        end
    end

endmodule
